// File: rtl/cv32e40p_apu_core_pkg.sv
// cv32e40p_apu_core_pkg: APU interface widths shared by the core and the FPU issue logic
package cv32e40p_apu_core_pkg;
  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;
endpackage

// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg: core-wide typedefs
package cv32e40p_pkg;
  typedef enum logic {APU_IDLE, APU_REQ} apu_state_e;
endpackage

// File: rtl/cv32e40p_apu_rd_fifo.sv
// cv32e40p_apu_rd_fifo: in-order FIFO of destination registers for granted, unanswered APU ops
module cv32e40p_apu_rd_fifo #(
  parameter int DEPTH = 2,
  parameter int RD_W  = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [RD_W-1:0] data_i,
  output logic [RD_W-1:0] data_o,
  output logic            empty_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [RD_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign empty_o = cnt == '0;
  assign data_o  = mem[rd_ptr];
  // pointers and fill count; the issue logic never pushes when full or pops when empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) wr_ptr <= inc(wr_ptr);
      if (pop_i) rd_ptr <= inc(rd_ptr);
      cnt <= cnt + CW'(push_i) - CW'(pop_i);
    end
  end
  // storage needs no reset: entries are only read once written
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= data_i;
  end
endmodule

// File: rtl/cv32e40p_apu_issue.sv
// cv32e40p_apu_issue: issues core ops to the FPU, tracks outstanding rd and registers writebacks
module cv32e40p_apu_issue
  import cv32e40p_apu_core_pkg::*, cv32e40p_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RD_W  = 6
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic [APU_NARGS_CPU*32-1:0]   issue_operands_i,
  input  logic [APU_WOP_CPU-1:0]        issue_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0]   issue_flags_i,
  input  logic [RD_W-1:0]               issue_rd_i,
  output logic                          apu_req_o,
  input  logic                          apu_gnt_i,
  output logic [APU_NARGS_CPU*32-1:0]   apu_operands_o,
  output logic [APU_WOP_CPU-1:0]        apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]   apu_flags_o,
  input  logic                          apu_rvalid_i,
  input  logic [31:0]                   apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]   apu_rflags_i,
  output logic                          wb_valid_o,
  output logic [RD_W-1:0]               wb_rd_o,
  output logic [31:0]                   wb_data_o,
  output logic [APU_NUSFLAGS_CPU-1:0]   wb_flags_o,
  output logic [APU_NUSFLAGS_CPU-1:0]   fflags_o,
  input  logic                          fflags_clr_i,
  output logic                          busy_o,
  output logic                          proto_err_o
);
  localparam int OW = $clog2(DEPTH + 1);
  apu_state_e      state, state_nx;
  logic [OW-1:0]   occ;
  logic [RD_W-1:0] rd_q, head_rd;
  logic            fifo_empty, accept, gnt, bypass, resp_ok;
  assign gnt           = state == APU_REQ && apu_gnt_i;
  assign bypass        = apu_rvalid_i && gnt && fifo_empty;
  assign resp_ok       = apu_rvalid_i && (!fifo_empty || gnt);
  assign issue_ready_o = (state == APU_IDLE || apu_gnt_i) && (occ < OW'(DEPTH) || apu_rvalid_i);
  assign accept        = issue_valid_i && issue_ready_o;
  assign apu_req_o     = state == APU_REQ;
  assign busy_o        = occ != '0;
  // a new accept always (re)enters REQ; otherwise a grant releases the request
  always_comb state_nx = accept ? APU_REQ : gnt ? APU_IDLE : state;
  cv32e40p_apu_rd_fifo #(.DEPTH(DEPTH), .RD_W(RD_W)) u_rd_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt && !bypass),
    .pop_i   (apu_rvalid_i && !fifo_empty),
    .data_i  (rd_q),
    .data_o  (head_rd),
    .empty_o (fifo_empty)
  );
  // request state, occupancy and the payload held stable while waiting for grant
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= APU_IDLE;
      occ            <= '0;
      rd_q           <= '0;
      apu_operands_o <= '0;
      apu_op_o       <= '0;
      apu_flags_o    <= '0;
    end else begin
      state <= state_nx;
      occ   <= occ + OW'(accept) - OW'(resp_ok);
      if (accept) begin
        rd_q           <= issue_rd_i;
        apu_operands_o <= issue_operands_i;
        apu_op_o       <= issue_op_i;
        apu_flags_o    <= issue_flags_i;
      end
    end
  end
  // registered writeback, sticky exception flags and orphan-response detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o  <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      wb_flags_o  <= '0;
      fflags_o    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      wb_valid_o <= resp_ok;
      if (resp_ok) begin
        wb_rd_o    <= fifo_empty ? rd_q : head_rd;
        wb_data_o  <= apu_rdata_i;
        wb_flags_o <= apu_rflags_i;
      end
      fflags_o    <= fflags_clr_i ? '0 : fflags_o | (resp_ok ? apu_rflags_i : '0);
      proto_err_o <= proto_err_o | (apu_rvalid_i && !resp_ok);
    end
  end
endmodule

// File: tb/tb_cv32e40p_apu_issue.sv
// tb_cv32e40p_apu_issue: randomized scoreboard bench with an FPU model and reference queues
module tb_cv32e40p_apu_issue;
  import cv32e40p_apu_core_pkg::*;
  localparam int DEPTH = 2;
  localparam int RD_W  = 6;
  localparam int NA    = APU_NARGS_CPU * 32;
  localparam int NUS   = APU_NUSFLAGS_CPU;

  logic                        clk, rst;
  logic                        issue_valid_i, issue_ready_o;
  logic [NA-1:0]               issue_operands_i;
  logic [APU_WOP_CPU-1:0]      issue_op_i;
  logic [APU_NDSFLAGS_CPU-1:0] issue_flags_i;
  logic [RD_W-1:0]             issue_rd_i;
  logic                        apu_req_o, apu_gnt_i;
  logic [NA-1:0]               apu_operands_o;
  logic [APU_WOP_CPU-1:0]      apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0] apu_flags_o;
  logic                        apu_rvalid_i;
  logic [31:0]                 apu_rdata_i;
  logic [NUS-1:0]              apu_rflags_i;
  logic                        wb_valid_o;
  logic [RD_W-1:0]             wb_rd_o;
  logic [31:0]                 wb_data_o;
  logic [NUS-1:0]              wb_flags_o, fflags_o;
  logic                        fflags_clr_i, busy_o, proto_err_o;

  cv32e40p_apu_issue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_operands_i(issue_operands_i), .issue_op_i(issue_op_i),
    .issue_flags_i(issue_flags_i), .issue_rd_i(issue_rd_i),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_flags_o(wb_flags_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .busy_o(busy_o), .proto_err_o(proto_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NA-1:0]               opnd;
    logic [APU_WOP_CPU-1:0]      op;
    logic [APU_NDSFLAGS_CPU-1:0] fl;
    logic [RD_W-1:0]             rd;
  } op_t;
  typedef struct {
    logic [RD_W-1:0] rd;
    int              due;
  } fly_t;
  typedef struct {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic [NUS-1:0]  fl;
    time             t;
  } wb_t;

  op_t  pend[$];
  fly_t infl[$];
  wb_t  exp_wb[$];
  int   checks = 0, errors = 0, cyc = 0, last_due = -1;
  logic [NUS-1:0] ff_m = '0;
  logic perr_m = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // writeback monitor: every strobe must match the oldest expected response, on time
  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_valid_o) begin
      if (exp_wb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got rd %0h expected no writeback", wb_rd_o);
      end else begin
        e = exp_wb.pop_front();
        chk("wb_rd", wb_rd_o, e.rd);
        chk("wb_data", wb_data_o, e.data);
        chk("wb_flags", wb_flags_o, e.fl);
        chk("wb_time", $time, e.t);
      end
    end
  end

  // one cycle: check registered outputs, drive random stimulus, advance the reference model
  task automatic cycle(input bit allow_issue, input int gnt_pct, input int maxlat,
                       input bit clr_en, input bit spur);
    op_t  o;
    fly_t f;
    bit   g, rv, exp_ready, acc;
    int   occ_m, d;
    @(negedge clk);
    occ_m = pend.size() + infl.size();
    chk("apu_req", apu_req_o, pend.size() != 0);
    chk("busy", busy_o, occ_m != 0);
    chk("fflags", fflags_o, ff_m);
    chk("proto_err", proto_err_o, perr_m);
    if (pend.size() != 0) begin
      chk("apu_operands", apu_operands_o, pend[0].opnd);
      chk("apu_op", apu_op_o, pend[0].op);
      chk("apu_flags", apu_flags_o, pend[0].fl);
    end
    for (int i = 0; i < APU_NARGS_CPU; i++) o.opnd[i*32 +: 32] = $urandom;
    o.op = APU_WOP_CPU'($urandom);
    o.fl = APU_NDSFLAGS_CPU'($urandom);
    o.rd = RD_W'($urandom);
    issue_valid_i    = allow_issue && $urandom_range(0, 3) != 0;
    issue_operands_i = o.opnd;
    issue_op_i       = o.op;
    issue_flags_i    = o.fl;
    issue_rd_i       = o.rd;
    g = pend.size() != 0 && $urandom_range(0, 99) < gnt_pct;
    apu_gnt_i = pend.size() != 0 ? g : 1'($urandom_range(0, 1));
    if (g) begin
      d = cyc + $urandom_range(0, maxlat);
      f.rd  = pend[0].rd;
      f.due = d > last_due ? d : last_due + 1;
      last_due = f.due;
      infl.push_back(f);
    end
    rv = infl.size() != 0 && infl[0].due <= cyc;
    apu_rvalid_i = rv || spur;
    apu_rdata_i  = $urandom;
    apu_rflags_i = NUS'($urandom);
    fflags_clr_i = clr_en && $urandom_range(0, 15) == 0;
    #1;
    exp_ready = (pend.size() == 0 || g) && (occ_m < DEPTH || apu_rvalid_i);
    chk("issue_ready", issue_ready_o, exp_ready);
    acc = issue_valid_i && exp_ready;
    if (rv) begin
      f = infl.pop_front();
      exp_wb.push_back('{f.rd, apu_rdata_i, apu_rflags_i, $time + 9});
    end
    if (spur && !rv) perr_m = 1'b1;
    ff_m = fflags_clr_i ? '0 : ff_m | (rv ? apu_rflags_i : '0);
    if (g) void'(pend.pop_front());
    if (acc) pend.push_back(o);
    cyc++;
  endtask

  task automatic idle_inputs();
    issue_valid_i = 1'b0;
    apu_gnt_i     = 1'b0;
    apu_rvalid_i  = 1'b0;
    fflags_clr_i  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name, {apu_req_o, apu_operands_o, apu_op_o, apu_flags_o, wb_valid_o, wb_rd_o,
               wb_data_o, wb_flags_o, fflags_o, busy_o, proto_err_o}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit reached;
    rst = 1'b1;
    idle_inputs();
    issue_operands_i = '0;
    issue_op_i       = '0;
    issue_flags_i    = '0;
    issue_rd_i       = '0;
    apu_rdata_i      = '0;
    apu_rflags_i     = '0;
    #3;
    check_reset_outputs("reset_outputs");
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 300; i++) cycle(1, 100, 0, 0, 0);
    for (int i = 0; i < 600; i++) cycle(1, 40, 4, 1, 0);
    for (int i = 0; i < 300; i++) cycle(1, 70, 3, 1, 0);
    for (int i = 0; i < 30; i++) cycle(0, 100, 0, 0, 0);
    chk("drained", exp_wb.size() + pend.size() + infl.size(), 0);
    cycle(0, 100, 0, 0, 1);
    cycle(0, 100, 0, 0, 0);
    cycle(0, 100, 0, 0, 0);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cycle(1, 100, 40, 0, 0);
      reached = infl.size() == DEPTH;
    end
    chk("two_outstanding_reached", reached, 1'b1);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset_outputs");
    pend.delete();
    infl.delete();
    exp_wb.delete();
    ff_m     = '0;
    perr_m   = 1'b0;
    last_due = cyc - 1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ready_after_reset", issue_ready_o, 1'b1);
    chk("busy_after_reset", busy_o, 1'b0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
